vga_fb_scanout: RTL and testbench
=================================

// Module: vga_fb_scanout
// PURPOSE
// - Reader end of the 160x120x3-bit pixel framebuffer. The title, game-over and game drawers write this buffer
//   as address = y*160 + x.
// - Generates 640x480@60 VGA timing on a 25 MHz pixel clock and scans the buffer once per frame.
// - Upscales each framebuffer pixel to a 4x4 block and expands 3-bit RGB to 8-bit DAC channels.
// - Also exports a vblank level and a frame_start pulse, so drawers can sequence full-screen redraws.
// PARAMETERS
// H_VIS 640 visible px/line; H_FP 16; H_SYNC 96; H_BP 48 (H_TOTAL = 800)
// V_VIS 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (V_TOTAL = 525)
// SCALE_SHIFT 2   log2 of upscale factor (4x4)
// FB_W 160   framebuffer width; FB_H 120 framebuffer height; ADDR_W 15
// PORTS
// clk          in   1   25 MHz pixel clock
// rst          in   1   asynchronous, active-low reset
// fb_addr      out  15  framebuffer read address to the sync RAM read port
// fb_q         in   3   RAM data {R,G,B}, valid exactly 1 clk after fb_addr is sampled
// vga_r/g/b    out  8   colour channels
// vga_hs       out  1   hsync, active low
// vga_vs       out  1   vsync, active low
// vga_blank_n  out  1   high during visible region
// vga_sync_n   out  1   tied 0 (no sync-on-green)
// vblank       out  1   high while output-aligned vcount >= V_VIS
// frame_start  out  1   1-clk pulse coincident with output pixel (0,0)
// BEHAVIOUR
// - Reset (rst=0, async): hcount=vcount=0; fb_addr=0; vga_r/g/b=0; vga_hs=vga_vs=1; vga_blank_n=0;
//   vblank=0; frame_start=0; all pipeline stages cleared to these idle values.
// - Stage 0 (timing counters):
//   - hcount 0..H_TOTAL-1 wraps to 0; on that wrap vcount increments.
//   - vcount 0..V_TOTAL-1 wraps to 0 when hcount also wraps.
// - Stage 1 (address register):
//   - visible if hcount<H_VIS && vcount<V_VIS.
//   - If visible: fb_addr <= (vcount>>2)*160 + (hcount>>2), computed as (v<<7)+(v<<5)+h; max 19199.
//   - If blanking: fb_addr <= 0; never exceeds FB_W*FB_H-1.
// - Stage 2: fb_q valid (RAM latency 1).
// - Stage 3 (output register): outputs registered.
//   - Colour channel = {8{bit}} for R=q[2], G=q[1], B=q[0].
//   - Colour forced 0 when the delayed visible flag is 0.
// - Sideband alignment:
//   - hs/vs/visible/vblank/frame_start are derived in stage 0 and delayed by 3 flops.
//   - Total latency from counter position to pin = 3 clk for every output.
// - Sync windows:
//   - hs low for H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC (656..751).
//   - vs low for 490 <= vcount < 492.
// - frame_start is derived from hcount==0 && vcount==0, so it pulses once per 420000 clk.
// - fb_q is sampled every clk. It is ignored (colour 0) during blanking, and no handshake exists.
// - Mid-frame reset: counters restart at (0,0) and outputs go idle immediately.
//   - The first frame after release is full-length.
//   - The first frame_start appears 3 clk after release.
// STRUCTURE
// - Shared package vga_pkg:
//   - timing localparams (H_*/V_*, totals, sync windows);
//   - FB_W/FB_H/ADDR_W;
//   - colour constants BLACK=3'b000, RED=3'b100.
// - Sub-module vga_timing: counters plus hs/vs/visible/frame_start generation (stage 0).
// - This module adds address generation, the 3-deep sideband delay line and colour expansion.
// TESTING
// - Release rst, run 2 frames, then check periods:
//   - hs period 800 clk, low for 96;
//   - vs period 420000 clk, low for 2 lines (1600 clk);
//   - frame_start spacing 420000.
// - RAM model holds fb[a]=a[2:0], then check addressing at output:
//   - output px (0,0) -> fb_addr 0;
//   - (4,0) -> 1; (639,479) -> 19199; (0,4) -> 160.
// - Fill RAM with 3'b100 at address 161, else 0; colour at pins:
//   - rows 4..7, cols 4..7: r=8'hFF, g=b=0;
//   - all other pixels: 0.
// - Drive fb_q=3'b111 constantly, then check blanking:
//   - colour 0 and blank_n=0 for hcount 640..799 and vcount 480..524;
//   - vblank=1 exactly over those lines.
// - Latency: compare pins vs an internal counter model.
//   - frame_start, blank_n rise and first colour all land 3 clk after counter (0,0).
// - Assert rst mid-line (hcount=300, vcount=200): outputs idle that cycle; after release,
//   frame_start fires at clk 3 and full timing resumes.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster constants, framebuffer geometry and the sideband bundle for the scanout path.
// Pure definitions; no latency or backpressure of its own.
package vga_pkg;

   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_VIS + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VIS + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int SCALE_SHIFT = 2;
   localparam int FB_W        = 160;
   localparam int FB_H        = 120;
   localparam int ADDR_W      = 15;
   localparam int CNT_W       = 10;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] RED   = 3'b100;

   typedef struct packed {
      logic hs;
      logic vs;
      logic vis;
      logic vblank;
      logic fs;
   } sideband_t;

   localparam sideband_t SB_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, vblank: 1'b0, fs: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus combinational sync/visible/vblank/frame-start flags (stage 0, no added latency).
// Free-running; no backpressure.
module vga_timing import vga_pkg::*; #(
   parameter int H_VIS_P  = H_VIS,
   parameter int H_FP_P   = H_FP,
   parameter int H_SYNC_P = H_SYNC,
   parameter int H_BP_P   = H_BP,
   parameter int V_VIS_P  = V_VIS,
   parameter int V_FP_P   = V_FP,
   parameter int V_SYNC_P = V_SYNC,
   parameter int V_BP_P   = V_BP
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] hcount_o,
   output logic [CNT_W-1:0] vcount_o,
   output sideband_t        sb_o
);

   localparam int HT    = H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P;
   localparam int VT    = V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P;
   localparam int HS_LO = H_VIS_P + H_FP_P;
   localparam int HS_HI = HS_LO + H_SYNC_P;
   localparam int VS_LO = V_VIS_P + V_FP_P;
   localparam int VS_HI = VS_LO + V_SYNC_P;

   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == CNT_W'(HT - 1)) begin
         h_d = '0;
         v_d = (v_q == CNT_W'(VT - 1)) ? '0 : v_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   always_comb begin
      sb_o        = SB_IDLE;
      sb_o.hs     = !(h_q >= CNT_W'(HS_LO) && h_q < CNT_W'(HS_HI));
      sb_o.vs     = !(v_q >= CNT_W'(VS_LO) && v_q < CNT_W'(VS_HI));
      sb_o.vis    = (h_q < CNT_W'(H_VIS_P)) && (v_q < CNT_W'(V_VIS_P));
      sb_o.vblank = (v_q >= CNT_W'(V_VIS_P));
      sb_o.fs     = (h_q == '0) && (v_q == '0);
   end

   assign hcount_o = h_q;
   assign vcount_o = v_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: 4x4-upscaled 160x120x3 buffer to 640x480@60 VGA pins, 3 clk counter-to-pin.
// Reads the RAM every clk with no handshake; nothing can stall the raster.
module vga_fb_scanout import vga_pkg::*; #(
   parameter int H_VIS_P  = H_VIS,
   parameter int H_FP_P   = H_FP,
   parameter int H_SYNC_P = H_SYNC,
   parameter int H_BP_P   = H_BP,
   parameter int V_VIS_P  = V_VIS,
   parameter int V_FP_P   = V_FP,
   parameter int V_SYNC_P = V_SYNC,
   parameter int V_BP_P   = V_BP
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [2:0]        fb_q,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank_n,
   output logic              vga_sync_n,
   output logic              vblank,
   output logic              frame_start
);

   logic [CNT_W-1:0]  hcount, vcount;
   sideband_t         sb0, sb1_q, sb2_q, sb3_q;
   logic [ADDR_W-1:0] fy, fx, addr_d, addr_q;
   logic [2:0]        rgb_d, rgb_q;

   vga_timing #(
      .H_VIS_P (H_VIS_P),  .H_FP_P (H_FP_P),  .H_SYNC_P (H_SYNC_P),  .H_BP_P (H_BP_P),
      .V_VIS_P (V_VIS_P),  .V_FP_P (V_FP_P),  .V_SYNC_P (V_SYNC_P),  .V_BP_P (V_BP_P)
   ) u_timing (
      .clk      (clk),
      .rst      (rst),
      .hcount_o (hcount),
      .vcount_o (vcount),
      .sb_o     (sb0)
   );

   // y*160 built from shifts; blanking parks the address at 0 so it never leaves the buffer.
   always_comb begin
      fy     = ADDR_W'(vcount >> SCALE_SHIFT);
      fx     = ADDR_W'(hcount >> SCALE_SHIFT);
      addr_d = sb0.vis ? (fy << 7) + (fy << 5) + fx : '0;
      rgb_d  = sb2_q.vis ? fb_q : BLACK;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         sb1_q  <= SB_IDLE;
         sb2_q  <= SB_IDLE;
         sb3_q  <= SB_IDLE;
         rgb_q  <= BLACK;
      end else begin
         addr_q <= addr_d;
         sb1_q  <= sb0;
         sb2_q  <= sb1_q;
         sb3_q  <= sb2_q;
         rgb_q  <= rgb_d;
      end
   end

   assign fb_addr     = addr_q;
   assign vga_r       = {8{rgb_q[2]}};
   assign vga_g       = {8{rgb_q[1]}};
   assign vga_b       = {8{rgb_q[0]}};
   assign vga_hs      = sb3_q.hs;
   assign vga_vs      = sb3_q.vs;
   assign vga_blank_n = sb3_q.vis;
   assign vga_sync_n  = 1'b0;
   assign vblank      = sb3_q.vblank;
   assign frame_start = sb3_q.fs;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: a full-size raster instance plus a shrunken-raster instance for whole frames.
// Both are checked every cycle against a position-arithmetic model, plus pinned literal expectations.
module tb_vga_fb_scanout;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #20 clk = ~clk;

   logic [14:0] fb_addr_s, fb_addr_f;
   logic [2:0]  fb_q_s, fb_q_f;
   logic [7:0]  r_s, g_s, b_s, r_f, g_f, b_f;
   logic        hs_s, vs_s, bn_s, sn_s, vb_s, fs_s;
   logic        hs_f, vs_f, bn_f, sn_f, vb_f, fs_f;

   logic [2:0] mem [0:19199];
   int cmps = 0;
   int errs = 0;
   int k = 0;

   vga_fb_scanout #(
      .H_VIS_P (64), .H_FP_P (4), .H_SYNC_P (8), .H_BP_P (4),
      .V_VIS_P (40), .V_FP_P (2), .V_SYNC_P (2), .V_BP_P (3)
   ) dut_s (
      .clk (clk), .rst (rst), .fb_addr (fb_addr_s), .fb_q (fb_q_s),
      .vga_r (r_s), .vga_g (g_s), .vga_b (b_s), .vga_hs (hs_s), .vga_vs (vs_s),
      .vga_blank_n (bn_s), .vga_sync_n (sn_s), .vblank (vb_s), .frame_start (fs_s)
   );

   vga_fb_scanout dut_f (
      .clk (clk), .rst (rst), .fb_addr (fb_addr_f), .fb_q (fb_q_f),
      .vga_r (r_f), .vga_g (g_f), .vga_b (b_f), .vga_hs (hs_f), .vga_vs (vs_f),
      .vga_blank_n (bn_f), .vga_sync_n (sn_f), .vblank (vb_f), .frame_start (fs_f)
   );

   // Synchronous-read RAM, one clk of latency.
   always @(posedge clk) begin
      fb_q_s <= mem[fb_addr_s];
      fb_q_f <= mem[fb_addr_f];
   end

   // Clocks elapsed since reset release; the raster position after k clocks is k mod frame length.
   always @(posedge clk or negedge rst) begin
      if (!rst) k <= 0;
      else      k <= k + 1;
   end

   // Expected {addr, r, g, b, hs, vs, blank_n, sync_n, vblank, frame_start} after k clocks.
   function automatic logic [44:0] model(input int kk, input int hv, input int hf, input int hsy,
                                         input int hb, input int vv, input int vf, input int vsy,
                                         input int vb);
      int ht, vt, q, h, v;
      logic [14:0] a;
      logic [2:0]  px;
      logic        hs, vs, bn, vbl, fs;
      ht = hv + hf + hsy + hb;
      vt = vv + vf + vsy + vb;
      a = '0;
      px = 3'b000;
      hs = 1'b1; vs = 1'b1; bn = 1'b0; vbl = 1'b0; fs = 1'b0;
      if (kk >= 1) begin
         q = (kk - 1) % (ht * vt);
         h = q % ht;
         v = q / ht;
         if (h < hv && v < vv) a = 15'((v / 4) * 160 + h / 4);
      end
      if (kk >= 3) begin
         q = (kk - 3) % (ht * vt);
         h = q % ht;
         v = q / ht;
         bn  = (h < hv && v < vv);
         hs  = !(h >= hv + hf && h < hv + hf + hsy);
         vs  = !(v >= vv + vf && v < vv + vf + vsy);
         vbl = (v >= vv);
         fs  = (h == 0 && v == 0);
         if (bn) px = mem[(v / 4) * 160 + h / 4];
      end
      return {a, {8{px[2]}}, {8{px[1]}}, {8{px[0]}}, hs, vs, bn, 1'b0, vbl, fs};
   endfunction

   logic [44:0] exp_s, exp_f, got_s, got_f;

   always @(negedge clk) begin
      exp_s = model(k, 64, 4, 8, 4, 40, 2, 2, 3);
      got_s = {fb_addr_s, r_s, g_s, b_s, hs_s, vs_s, bn_s, sn_s, vb_s, fs_s};
      cmps++;
      if (got_s !== exp_s) begin
         errs++;
         $display("FAIL model_small k=%0d got %h expected %h", k, got_s, exp_s);
      end
      exp_f = model(k, 640, 16, 96, 48, 480, 10, 2, 33);
      got_f = {fb_addr_f, r_f, g_f, b_f, hs_f, vs_f, bn_f, sn_f, vb_f, fs_f};
      cmps++;
      if (got_f !== exp_f) begin
         errs++;
         $display("FAIL model_full k=%0d got %h expected %h", k, got_f, exp_f);
      end
   end

   task automatic chk(input string name, input logic [47:0] got, input logic [47:0] expv);
      cmps++;
      if (got !== expv) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   task automatic wait_k(input int target);
      int n;
      n = 0;
      while (k != target && n < 50000) begin
         @(negedge clk);
         n++;
      end
      if (k != target) begin
         cmps++;
         errs++;
         $display("FAIL wait_k timeout: k=%0d required %0d", k, target);
      end
   endtask

   function automatic logic act(input int sel);
      case (sel)
         0:       return !hs_s;
         1:       return !vs_s;
         2:       return fs_s;
         default: return !hs_f;
      endcase
   endfunction

   task automatic meas(input int sel, input int exp_w, input int exp_p, input string name);
      int n, w, p;
      logic prev, cur, found;
      n = 0;
      found = 1'b0;
      @(negedge clk);
      prev = act(sel);
      while (!found && n < 20000) begin
         @(negedge clk);
         n++;
         cur = act(sel);
         found = cur && !prev;
         prev = cur;
      end
      if (!found) begin
         cmps++;
         errs++;
         $display("FAIL %s onset timeout: got none required one", name);
         return;
      end
      w = 0;
      do begin
         w++;
         @(negedge clk);
      end while (act(sel) && w < 20000);
      p = w;
      while (!act(sel) && p < 20000) begin
         @(negedge clk);
         p++;
      end
      chk({name, "_width"}, 48'(w), 48'(exp_w));
      chk({name, "_period"}, 48'(p), 48'(exp_p));
   endtask

   task automatic fill(input int mode);
      for (int a = 0; a < 19200; a++) begin
         if (mode == 0)      mem[a] = 3'(a);
         else if (mode == 1) mem[a] = (a == 161) ? 3'b100 : 3'b000;
         else                mem[a] = 3'b111;
      end
   endtask

   task automatic restart(input int mode);
      @(posedge clk);
      #5 rst = 1'b0;
      fill(mode);
      repeat (3) @(posedge clk);
      #5 rst = 1'b1;
   endtask

   initial begin
      fill(0);
      repeat (3) @(negedge clk);
      chk("reset_small", {3'b0, fb_addr_s, r_s, g_s, b_s, hs_s, vs_s, bn_s, sn_s, vb_s, fs_s},
          {3'b0, 15'd0, 24'd0, 6'b110000});
      chk("reset_full", {3'b0, fb_addr_f, r_f, g_f, b_f, hs_f, vs_f, bn_f, sn_f, vb_f, fs_f},
          {3'b0, 15'd0, 24'd0, 6'b110000});
      @(posedge clk);
      #5 rst = 1'b1;

      // Address pattern: fb[a] = a[2:0].
      wait_k(1);    chk("addr_px0_0", 48'(fb_addr_f), 48'd0);
      wait_k(5);    chk("addr_px4_0", 48'(fb_addr_f), 48'd1);
      wait_k(7);    chk("rgb_px4_0", {24'd0, r_f, g_f, b_f}, {24'd0, 24'h0000FF});
      wait_k(3184); chk("addr_small_last", 48'(fb_addr_s), 48'd1455);
      wait_k(3186); chk("rgb_small_last", {24'd0, r_s, g_s, b_s}, {24'd0, 24'hFFFFFF});
      wait_k(3201); chk("addr_px0_4", 48'(fb_addr_f), 48'd160);
      meas(0, 8, 80, "hs_small");
      meas(1, 160, 3760, "vs_small");
      meas(2, 1, 3760, "fs_small");
      meas(3, 96, 800, "hs_full");

      // Single red framebuffer pixel at (1,1).
      restart(1);
      wait_k(327);  chk("red_s_4_4", {24'd0, r_s, g_s, b_s}, {24'd0, 24'hFF0000});
      wait_k(331);  chk("red_s_8_4", {24'd0, r_s, g_s, b_s}, 48'd0);
      wait_k(570);  chk("red_s_7_7", {24'd0, r_s, g_s, b_s}, {24'd0, 24'hFF0000});
      wait_k(647);  chk("red_s_4_8", {24'd0, r_s, g_s, b_s}, 48'd0);
      wait_k(3207); chk("red_f_4_4", {24'd0, r_f, g_f, b_f}, {24'd0, 24'hFF0000});
      wait_k(3211); chk("red_f_8_4", {24'd0, r_f, g_f, b_f}, 48'd0);

      // All-white buffer: blanking must still force black.
      restart(2);
      wait_k(66);   chk("white_last_col", {23'd0, bn_s, r_s, g_s, b_s}, {23'd0, 1'b1, 24'hFFFFFF});
      wait_k(67);   chk("hblank_col64", {23'd0, bn_s, r_s, g_s, b_s}, 48'd0);
      wait_k(3202); chk("vblank_pre", 48'(vb_s), 48'd0);
      wait_k(3203); chk("vblank_start", {23'd0, vb_s, r_s, g_s, b_s}, {23'd0, 1'b1, 24'd0});
      wait_k(3762); chk("vblank_end", 48'(vb_s), 48'd1);
      wait_k(3763); chk("frame2_start", {45'd0, fs_s, vb_s, bn_s}, {45'd0, 3'b101});

      // Mid-line reset at small-raster position (30,20) of the second frame.
      wait_k(3760 + 20 * 80 + 30);
      #5 rst = 1'b0;
      #1;
      chk("midrst_small", {3'b0, fb_addr_s, r_s, g_s, b_s, hs_s, vs_s, bn_s, sn_s, vb_s, fs_s},
          {3'b0, 15'd0, 24'd0, 6'b110000});
      chk("midrst_full", {3'b0, fb_addr_f, r_f, g_f, b_f, hs_f, vs_f, bn_f, sn_f, vb_f, fs_f},
          {3'b0, 15'd0, 24'd0, 6'b110000});
      @(posedge clk);
      #5 rst = 1'b1;
      wait_k(2);    chk("fs_after_rst_clk2", {46'd0, fs_s, fs_f}, 48'd0);
      wait_k(3);    chk("fs_after_rst_clk3", {46'd0, fs_s, fs_f}, 48'd3);
      wait_k(3763 + 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
